// File: rtl/ucode_loader.sv
// Writable control store loader: unpacks a framed, checksummed byte stream into
// WORD_W-bit control words and holds the micro-sequencer until the image verifies.
module ucode_loader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WORD_W = 20,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [7:0]        i_s_data,
    output logic              o_wcs_we,
    output logic [ADDR_W-1:0] o_wcs_addr,
    output logic [WORD_W-1:0] o_wcs_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cpu_hold
);

    // Count register must hold DEPTH itself, so it is one bit wider than an address when DEPTH is a power of two.
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam logic [15:0] B2_MASK_W = 16'h00FF << (WORD_W - 16);
    localparam logic [7:0]  B2_MASK   = B2_MASK_W[7:0];
    localparam logic [7:0]  HDR_BYTE  = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CNT, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             r_state;
    logic               r_s_ready;
    logic               r_wcs_we;
    logic [ADDR_W-1:0]  r_wcs_addr;
    logic [WORD_W-1:0]  r_wcs_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_cpu_hold;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_csum;
    logic [7:0]         r_b0;
    logic [7:0]         r_b1;

    logic               w_xfer;
    logic               w_cnt_ok;
    logic               w_b2_ok;
    logic               w_last;
    logic [WORD_W-1:0]  w_word;

    assign w_xfer   = i_s_valid & r_s_ready;
    assign w_cnt_ok = (i_s_data != 8'd0) && (32'(i_s_data) <= DEPTH);
    assign w_b2_ok  = (i_s_data & B2_MASK) == 8'd0;
    assign w_last   = (r_idx == (r_cnt - CNT_W'(1)));
    assign w_word   = WORD_W'({i_s_data, r_b1, r_b0});

    // Frame parser, word packer and WCS write port; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_s_ready   <= 1'b0;
            r_wcs_we    <= 1'b0;
            r_wcs_addr  <= '0;
            r_wcs_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_csum      <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
        end else begin
            r_wcs_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        r_state    <= S_HDR;
                        r_s_ready  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_idx      <= '0;
                        r_csum     <= '0;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        if (i_s_data == HDR_BYTE) begin
                            r_state <= S_CNT;
                        end else begin
                            r_state   <= S_ERR;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
                end
                S_CNT: begin
                    if (w_xfer) begin
                        if (w_cnt_ok) begin
                            r_cnt   <= CNT_W'(i_s_data);
                            r_state <= S_B0;
                        end else begin
                            r_state   <= S_ERR;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
                end
                S_B0: begin
                    if (w_xfer) begin
                        r_b0    <= i_s_data;
                        r_csum  <= r_csum ^ i_s_data;
                        r_state <= S_B1;
                    end
                end
                S_B1: begin
                    if (w_xfer) begin
                        r_b1    <= i_s_data;
                        r_csum  <= r_csum ^ i_s_data;
                        r_state <= S_B2;
                    end
                end
                S_B2: begin
                    // Top byte is presented straight into the write data register; bits above WORD_W are illegal.
                    if (w_xfer) begin
                        if (w_b2_ok) begin
                            r_csum      <= r_csum ^ i_s_data;
                            r_wcs_we    <= 1'b1;
                            r_wcs_addr  <= ADDR_W'(r_idx);
                            r_wcs_wdata <= w_word;
                            r_s_ready   <= 1'b0;
                            r_state     <= S_WRITE;
                        end else begin
                            r_state   <= S_ERR;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_idx     <= r_idx + CNT_W'(1);
                    r_s_ready <= 1'b1;
                    r_state   <= w_last ? S_CSUM : S_B0;
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        if (i_s_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_s_ready   = r_s_ready;
    assign o_wcs_we    = r_wcs_we;
    assign o_wcs_addr  = r_wcs_addr;
    assign o_wcs_wdata = r_wcs_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_cpu_hold  = r_cpu_hold;

endmodule
